fp_operand_join: RTL
====================

// Module: fp_operand_join
// PURPOSE
//   Upstream feeder for the latency-insensitive FP adder wrapper.
//   Joins two independent ready/valid operand streams (A, B) into one
//   paired {a,b} ready/valid stream, buffering each side in a small FIFO.
//   Pairs leave strictly in arrival order per stream: the k-th A is always paired with the k-th B.
//   The output drives the adder wrapper's a/b/valid_in/ready_out ports directly.
// PARAMETERS
//   WIDTH  32  operand width in bits (IEEE-754 single)
//   DEPTH  4   per-stream FIFO entries; power of two, >= 2
// PORTS
//   clk         in   1                clock
//   reset       in   1                reset, synchronous, active-high
//   a_data      in   WIDTH            operand A payload
//   a_valid     in   1                A offered
//   a_ready     out  1                A accepted when a_valid && a_ready
//   b_data      in   WIDTH            operand B payload
//   b_valid     in   1                B offered
//   b_ready     out  1                B accepted when b_valid && b_ready
//   flush       in   1                synchronous clear of all buffered data
//   out_a       out  WIDTH            paired operand A
//   out_b       out  WIDTH            paired operand B
//   out_valid   out  1                pair available
//   out_ready   in   1                pair consumed when out_valid && out_ready
//   a_count     out  $clog2(DEPTH)+1  A FIFO occupancy
//   b_count     out  $clog2(DEPTH)+1  B FIFO occupancy
//   pair_count  out  32               pairs handed off since reset; wraps at 2^32
// BEHAVIOUR
//   - Reset: out_valid=0, out_a=out_b=0, a_count=b_count=0, pair_count=0,
//     all FIFO pointers=0. a_ready=b_ready=0 while reset is high.
//   - a_ready = (a_count < DEPTH) && !reset && !flush. b_ready is the same for B.
//     Ready never depends on out_ready or on same-cycle pops; there is no comb path out->in.
//   - FIFOs: push on a handshake, pop on output-register load. Push and pop in
//     the same cycle are legal; count holds. Pointers wrap modulo DEPTH.
//   - Output register loads when a_count>0 && b_count>0 && (!out_valid || out_ready).
//     The load pops both FIFO heads in the same cycle.
//   - out_valid is set on load. It clears on handshake when no new load happens that cycle.
//   - While out_valid && !out_ready, out_a/out_b/out_valid hold stable.
//   - Latency: if both operands are accepted at edge E, out_valid=1 after edge E+1.
//   - Throughput: 1 pair/clk while both streams are fed and out_ready=1.
//   - Missing partner: the unmatched side accumulates up to DEPTH entries, then
//     its ready drops. The other side stays ready.
//   - flush=1 at an edge: both FIFOs empty, out_valid=0, and no push or load happens.
//     pair_count is unchanged. A handshake on out in the flush cycle still counts.
//   - pair_count += 1 on each out_valid && out_ready, and wraps from 2^32-1 to 0.
//   - Reset mid-operation discards all buffered data; nothing is replayed.
// STRUCTURE
//   - Package fp_stream_pkg:
//     - FP_WIDTH=32
//     - typedef fp_word_t (logic [FP_WIDTH-1:0])
//     - typedef struct packed {fp_word_t a, b;} fp_pair_t
//     The adder LI wrapper and later stream blocks use the same package.
//   - Sub-module fp_stream_fifo #(WIDTH,DEPTH):
//     - sync FIFO with push/pop/flush/count/head_data
//     - instantiated twice, once for A and once for B
//   - The top level holds the join condition, output register and pair counter.
// TESTING
//   1. Reset, then 3 A pushes and no B -> out_valid stays 0, a_count=3, b_ready=1,
//      pair_count=0.
//   2. A=3F800000,40000000; B=40400000,40800000 arriving 3 clks later; out_ready=1
//      -> out pairs (3F800000,40400000) then (40000000,40800000); pair_count=2.
//   3. 4 A pushes with B idle (DEPTH=4) -> a_ready=0 after the 4th and the 5th A is
//      held. One B push -> a_ready returns to 1 within 2 clks.
//   4. out_ready=0 for 5 clks with both streams driven every clk -> out_a/out_b stable,
//      both FIFOs reach 4, no loss. out_ready=1 -> 1 pair/clk, order preserved.
//   5. flush with a_count=2, b_count=2, out_valid=1 -> next clk counts=0, out_valid=0,
//      pair_count unchanged. Subsequent pairs use only post-flush data.
//   6. Random valid/ready on all three ports, 10k clks, scoreboard against per-stream
//      queues -> no loss, duplication or misordering. Assert the stability rule.

Source files
------------

// File: rtl/fp_stream_pkg.sv
// Shared types for the FP operand stream blocks.
// Used by the operand join, the adder LI wrapper and later stream stages.
package fp_stream_pkg;

  localparam int FP_WIDTH = 32;

  typedef logic [FP_WIDTH-1:0] fp_word_t;

  typedef struct packed {
    fp_word_t a;
    fp_word_t b;
  } fp_pair_t;

endpackage

// File: rtl/fp_stream_fifo.sv
// Small synchronous FIFO for one operand stream.
// It has push, pop and flush inputs, and it exposes the head entry and the occupancy.
module fp_stream_fifo
  import fp_stream_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fp_operand_join.sv
// Joins two operand streams into one {a,b} pair stream for the FP adder wrapper.
// The k-th A is always paired with the k-th B. Input ready never depends on out_ready.
module fp_operand_join
  import fp_stream_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       a_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [WIDTH-1:0]       b_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic                   flush,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count,
  output logic [31:0]            pair_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] a_head, b_head;
  logic [CNT_W-1:0] a_cnt, b_cnt;
  logic             a_push, b_push, load, out_hs;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [31:0]      pair_count_q, pair_count_d;

  fp_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (a_push),
    .push_data (a_data),
    .pop       (load),
    .head_data (a_head),
    .count     (a_cnt)
  );

  fp_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (b_push),
    .push_data (b_data),
    .pop       (load),
    .head_data (b_head),
    .count     (b_cnt)
  );

  // Ready comes only from registered occupancy. This keeps out_ready off the input path.
  always_comb begin
    a_ready = (a_cnt < CNT_W'(DEPTH)) && !reset && !flush;
    b_ready = (b_cnt < CNT_W'(DEPTH)) && !reset && !flush;
    a_push  = a_valid && a_ready;
    b_push  = b_valid && b_ready;
    out_hs  = out_valid_q && out_ready;
    load    = (a_cnt != '0) && (b_cnt != '0) && (!out_valid_q || out_ready) && !flush;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    pair_count_d = pair_count_q + (out_hs ? 32'd1 : 32'd0);
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_a_d     = a_head;
      out_b_d     = b_head;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      pair_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign pair_count = pair_count_q;
  assign a_count    = a_cnt;
  assign b_count    = b_cnt;

endmodule
